// File: rtl/load_store_unit.sv
// Load/store initiator for a byte-addressed, big-endian, word-wide data memory.
// One request at a time; sub-word stores do read-modify-write.
module load_store_unit #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic        mem_write_enable
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [31:0] MAX_A = 32'(MEM_BYTES - 4);

  logic [1:0]  state_q, state_d;
  logic        wr_q, wr_d, uns_q, uns_d;
  logic [1:0]  size_q, size_d, off_q, off_d;
  logic [31:0] wdata_q, wdata_d;
  logic        ready_q, ready_d, rvalid_q, rvalid_d, err_q, err_d, mwe_q, mwe_d;
  logic [31:0] rdata_q, rdata_d, maddr_q, maddr_d, mwdata_q, mwdata_d;

  logic        acc, acc_err;
  logic [31:0] word_addr;
  logic [4:0]  sh;
  logic [31:0] mask, merged, ext;
  logic [15:0] lane;

  assign word_addr = {req_addr[31:2], 2'b00};
  assign acc       = req_valid && ready_q;
  assign acc_err   = (req_size == 2'b11) ||
                     (req_size == 2'b01 && req_addr[0]) ||
                     (req_size == 2'b10 && req_addr[1:0] != 2'b00) ||
                     (word_addr > MAX_A);

  // Big-endian lanes: byte o sits (3-o)*8 bits up, halfword o sits (2-o)*8 bits up.
  assign sh     = (size_q == 2'b00) ? {~off_q, 3'b000} : {~off_q[1], 4'b0000};
  assign mask   = (size_q == 2'b00) ? (32'h0000_00FF << sh) : (32'h0000_FFFF << sh);
  assign merged = (mem_read_data & ~mask) | ((wdata_q << sh) & mask);
  assign lane   = 16'(mem_read_data >> sh);

  always_comb begin
    ext = mem_read_data;
    case (size_q)
      2'b00:   ext = {uns_q ? 24'h0 : {24{lane[7]}}, lane[7:0]};
      2'b01:   ext = {uns_q ? 16'h0 : {16{lane[15]}}, lane};
      default: ext = mem_read_data;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    size_d   = size_q;
    uns_d    = uns_q;
    off_d    = off_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = 1'b0;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    mwe_d    = 1'b0;
    case (state_q)
      IDLE: if (acc) begin
        wr_d    = req_write;
        size_d  = req_size;
        uns_d   = req_unsigned;
        off_d   = req_addr[1:0];
        wdata_d = req_wdata;
        rdata_d = 32'h0;
        if (acc_err) begin
          state_d = RESP;
          err_d   = 1'b1;
        end else if (req_write && req_size == 2'b10) begin
          state_d  = WRITE;
          maddr_d  = word_addr;
          mwdata_d = req_wdata;
          mwe_d    = 1'b1;
        end else begin
          state_d = READ;
          maddr_d = word_addr;
        end
      end
      READ: if (wr_q) begin
        state_d  = WRITE;
        mwdata_d = merged;
        mwe_d    = 1'b1;
      end else begin
        state_d = RESP;
        rdata_d = ext;
      end
      WRITE:   state_d = RESP;
      default: state_d = IDLE;
    endcase
    ready_d  = (state_d == IDLE);
    rvalid_d = (state_d == RESP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_q     <= 1'b0;
      size_q   <= 2'b00;
      uns_q    <= 1'b0;
      off_q    <= 2'b00;
      wdata_q  <= 32'h0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0;
      maddr_q  <= 32'h0;
      mwdata_q <= 32'h0;
      mwe_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      off_q    <= off_d;
      wdata_q  <= wdata_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      mwe_q    <= mwe_d;
    end
  end

  assign req_ready        = ready_q;
  assign resp_valid       = rvalid_q;
  assign resp_error       = err_q;
  assign resp_rdata       = rdata_q;
  assign mem_address      = maddr_q;
  assign mem_write_data   = mwdata_q;
  assign mem_write_enable = mwe_q;

endmodule
